// File: rtl/branch_resolver_if.sv
// Branch resolver bus: fetch-side prediction enqueue, execute-side resolution,
// and the mispredict redirect / BTB update outputs.
//   pred_valid/pred_pc/pred_next -> enqueue request, pred_ready/pred_tag <- accept + tag
//   res_valid/res_tag/res_target -> actual outcome of an in-flight entry
//   flush/flush_pc/flush_src_pc  <- one-cycle redirect pulse (also BTB write)
//   mispredict_cnt               <- saturating flush counter
interface branch_resolver_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned TW = $clog2(DEPTH);

    logic          pred_valid;
    logic [31:0]   pred_pc;
    logic [31:0]   pred_next;
    logic          pred_ready;
    logic [TW-1:0] pred_tag;
    logic          res_valid;
    logic [TW-1:0] res_tag;
    logic [31:0]   res_target;
    logic          flush;
    logic [31:0]   flush_pc;
    logic [31:0]   flush_src_pc;
    logic [15:0]   mispredict_cnt;

    // Pipeline side (fetch + execute)
    modport master (
        output pred_valid, pred_pc, pred_next, res_valid, res_tag, res_target,
        input  pred_ready, pred_tag, flush, flush_pc, flush_src_pc, mispredict_cnt
    );

    // Resolver side
    modport slave (
        input  pred_valid, pred_pc, pred_next, res_valid, res_tag, res_target,
        output pred_ready, pred_tag, flush, flush_pc, flush_src_pc, mispredict_cnt
    );
endinterface

// File: rtl/branch_resolver.sv
// In-order branch resolution queue. Fetch enqueues predicted control-flow
// instructions at the tail; execute resolves them out of order by tag; the
// head retires in program order. A wrong prediction at retire raises a
// one-cycle flush with the redirect PC and the source PC for BTB update,
// clears the queue and spends two cycles (FLUSH, RECOVER) refusing traffic.
// Ports: clk, rst_n (async active-low), bus (branch_resolver_if.slave).
module branch_resolver #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    branch_resolver_if.slave    bus
);
    localparam int unsigned TW = $clog2(DEPTH);
    localparam int unsigned CW = TW + 1;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_FLUSH   = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic [DEPTH-1:0] valid_q, resolved_q;
    logic [31:0]   pc_q     [DEPTH];
    logic [31:0]   pnext_q  [DEPTH];
    logic [31:0]   actual_q [DEPTH];

    logic          flush_q;
    logic [31:0]   flush_pc_q, flush_src_pc_q;
    logic [15:0]   mis_cnt_q;

    logic          ready;
    logic          do_enq, do_res, do_retire, mispredict;

    // Acceptance depends only on registered state, so a full queue cannot
    // take an entry in the cycle that retires one.
    assign ready = (state_q == ST_RUN) && (count_q < CW'(DEPTH));

    // Next-state and per-cycle control decode
    always_comb begin
        state_d    = state_q;
        do_enq     = 1'b0;
        do_res     = 1'b0;
        do_retire  = 1'b0;
        mispredict = 1'b0;
        case (state_q)
            ST_RUN: begin
                do_enq = bus.pred_valid && ready;
                do_res = bus.res_valid && valid_q[bus.res_tag];
                if (valid_q[head_q] && resolved_q[head_q]) begin
                    do_retire = 1'b1;
                    if (actual_q[head_q] != pnext_q[head_q]) begin
                        mispredict = 1'b1;
                        state_d    = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH:   state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    // Control state; a mispredict overrides any same-cycle enqueue/resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            valid_q        <= '0;
            resolved_q     <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
            flush_src_pc_q <= '0;
            mis_cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= mispredict;
            if (mispredict) begin
                head_q         <= '0;
                tail_q         <= '0;
                count_q        <= '0;
                valid_q        <= '0;
                resolved_q     <= '0;
                flush_pc_q     <= actual_q[head_q];
                flush_src_pc_q <= pc_q[head_q];
                if (mis_cnt_q != 16'hFFFF) begin
                    mis_cnt_q <= mis_cnt_q + 16'd1;
                end
            end else begin
                if (do_res) begin
                    resolved_q[bus.res_tag] <= 1'b1;
                end
                // Retire clears after resolve so a late repeat resolve of the head is dropped
                if (do_retire) begin
                    valid_q[head_q]    <= 1'b0;
                    resolved_q[head_q] <= 1'b0;
                    head_q             <= head_q + TW'(1);
                end
                if (do_enq) begin
                    valid_q[tail_q]    <= 1'b1;
                    resolved_q[tail_q] <= 1'b0;
                    tail_q             <= tail_q + TW'(1);
                end
                count_q <= count_q + CW'(do_enq) - CW'(do_retire);
            end
        end
    end

    // Entry payload; qualified by valid_q so it needs no reset
    always_ff @(posedge clk) begin
        if (do_enq) begin
            pc_q[tail_q]    <= bus.pred_pc;
            pnext_q[tail_q] <= bus.pred_next;
        end
        if (do_res) begin
            actual_q[bus.res_tag] <= bus.res_target;
        end
    end

    assign bus.pred_ready     = ready;
    assign bus.pred_tag       = tail_q;
    assign bus.flush          = flush_q;
    assign bus.flush_pc       = flush_pc_q;
    assign bus.flush_src_pc   = flush_src_pc_q;
    assign bus.mispredict_cnt = mis_cnt_q;
endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TW    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    branch_resolver_if #(.DEPTH(DEPTH)) bus ();
    branch_resolver #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic          pv;
        logic [31:0]   pc;
        logic [31:0]   pn;
        logic          rv;
        logic [TW-1:0] rtag;
        logic [31:0]   rt;
        logic          e_ready;
        logic [TW-1:0] e_tag;
        logic          e_flush;
        logic [31:0]   e_fpc;
        logic [31:0]   e_src;
        logic [15:0]   e_cnt;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic r, input logic [TW-1:0] t, input logic f,
                           input logic [31:0] fpc, input logic [31:0] src, input logic [15:0] c);
        chk({nm, ".ready"}, 32'(bus.pred_ready), 32'(r));
        chk({nm, ".tag"}, 32'(bus.pred_tag), 32'(t));
        chk({nm, ".flush"}, 32'(bus.flush), 32'(f));
        chk({nm, ".flush_pc"}, bus.flush_pc, fpc);
        chk({nm, ".src_pc"}, bus.flush_src_pc, src);
        chk({nm, ".cnt"}, 32'(bus.mispredict_cnt), 32'(c));
    endtask

    task automatic idle();
        bus.pred_valid = 1'b0;
        bus.pred_pc    = '0;
        bus.pred_next  = '0;
        bus.res_valid  = 1'b0;
        bus.res_tag    = '0;
        bus.res_target = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic enq(input logic [31:0] pc, input logic [31:0] pn);
        bus.pred_valid = 1'b1;
        bus.pred_pc    = pc;
        bus.pred_next  = pn;
        cyc();
        bus.pred_valid = 1'b0;
    endtask

    task automatic res(input logic [TW-1:0] tag, input logic [31:0] tgt);
        bus.res_valid  = 1'b1;
        bus.res_tag    = tag;
        bus.res_target = tgt;
        cyc();
        bus.res_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen_flush;
        logic [31:0] pn_m [DEPTH];

        // Each row: inputs for one cycle, outputs expected just after that cycle's closing edge
        //           pv  pc        pn        rv  rtag rt        rdy tag fl fpc     src     cnt
        tbl[0]  = '{1'b0, 32'h0,    32'h0,    1'b0, 3'd0, 32'h0,   1'b1, 3'd0, 1'b0, 32'h0,   32'h0,   16'd0};
        tbl[1]  = '{1'b1, 32'h100,  32'h104,  1'b0, 3'd0, 32'h0,   1'b1, 3'd1, 1'b0, 32'h0,   32'h0,   16'd0};
        tbl[2]  = '{1'b0, 32'h0,    32'h0,    1'b1, 3'd0, 32'h104, 1'b1, 3'd1, 1'b0, 32'h0,   32'h0,   16'd0};
        tbl[3]  = '{1'b0, 32'h0,    32'h0,    1'b0, 3'd0, 32'h0,   1'b1, 3'd1, 1'b0, 32'h0,   32'h0,   16'd0};
        tbl[4]  = '{1'b0, 32'h0,    32'h0,    1'b0, 3'd0, 32'h0,   1'b1, 3'd1, 1'b0, 32'h0,   32'h0,   16'd0};
        tbl[5]  = '{1'b1, 32'h200,  32'h204,  1'b0, 3'd0, 32'h0,   1'b1, 3'd2, 1'b0, 32'h0,   32'h0,   16'd0};
        tbl[6]  = '{1'b0, 32'h0,    32'h0,    1'b1, 3'd1, 32'h380, 1'b1, 3'd2, 1'b0, 32'h0,   32'h0,   16'd0};
        tbl[7]  = '{1'b1, 32'hAAA0, 32'hAAA4, 1'b0, 3'd0, 32'h0,   1'b0, 3'd0, 1'b1, 32'h380, 32'h200, 16'd1};
        tbl[8]  = '{1'b1, 32'hBBB0, 32'hBBB4, 1'b1, 3'd2, 32'h555, 1'b0, 3'd0, 1'b0, 32'h380, 32'h200, 16'd1};
        tbl[9]  = '{1'b1, 32'hCCC0, 32'hCCC4, 1'b0, 3'd0, 32'h0,   1'b1, 3'd0, 1'b0, 32'h380, 32'h200, 16'd1};
        tbl[10] = '{1'b1, 32'h300,  32'h304,  1'b0, 3'd0, 32'h0,   1'b1, 3'd1, 1'b0, 32'h380, 32'h200, 16'd1};
        tbl[11] = '{1'b0, 32'h0,    32'h0,    1'b1, 3'd0, 32'h304, 1'b1, 3'd1, 1'b0, 32'h380, 32'h200, 16'd1};
        tbl[12] = '{1'b0, 32'h0,    32'h0,    1'b0, 3'd0, 32'h0,   1'b1, 3'd1, 1'b0, 32'h380, 32'h200, 16'd1};

        idle();
        #2 rst_n = 1'b0;
        #1 chk_all("reset", 1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 16'd0);
        cyc();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_reset_ready", 32'(bus.pred_ready), 32'd1);

        // Correct prediction, then mispredict with wrong-path traffic during FLUSH/RECOVER
        for (int i = 0; i < 13; i++) begin
            bus.pred_valid = tbl[i].pv;
            bus.pred_pc    = tbl[i].pc;
            bus.pred_next  = tbl[i].pn;
            bus.res_valid  = tbl[i].rv;
            bus.res_tag    = tbl[i].rtag;
            bus.res_target = tbl[i].rt;
            cyc();
            chk_all($sformatf("row%0d", i), tbl[i].e_ready, tbl[i].e_tag, tbl[i].e_flush,
                    tbl[i].e_fpc, tbl[i].e_src, tbl[i].e_cnt);
        end
        idle();

        // Out-of-order resolution: younger mispredict waits behind two correct elders
        do_reset();
        enq(32'h1000, 32'h1004);
        enq(32'h2000, 32'h2004);
        enq(32'h3000, 32'h3004);
        res(3'd2, 32'h5000);
        res(3'd1, 32'h2004);
        res(3'd0, 32'h1004);
        cyc();
        chk("ooo_noflush_a", 32'(bus.flush), 32'd0);
        cyc();
        chk("ooo_noflush_b", 32'(bus.flush), 32'd0);
        cyc();
        chk_all("ooo_flush", 1'b0, 3'd0, 1'b1, 32'h5000, 32'h3000, 16'd1);

        // Fill, drop when full, free one slot, drain, and wrap the tag
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            chk($sformatf("fill_tag%0d", i), 32'(bus.pred_tag), 32'(i));
            pn_m[i] = 32'h4004 + 32'(i) * 32'd16;
            enq(32'h4000 + 32'(i) * 32'd16, pn_m[i]);
        end
        chk("full_ready", 32'(bus.pred_ready), 32'd0);
        enq(32'hDEAD, 32'hDEB1);
        chk("full_drop_ready", 32'(bus.pred_ready), 32'd0);
        chk("full_drop_tag", 32'(bus.pred_tag), 32'd0);
        res(3'd0, pn_m[0]);
        chk("resolved_still_full", 32'(bus.pred_ready), 32'd0);
        enq(32'hBEEF, 32'hBEF3);
        chk("freed_ready", 32'(bus.pred_ready), 32'd1);
        chk("freed_tag", 32'(bus.pred_tag), 32'd0);
        pn_m[0] = 32'h5004;
        enq(32'h5000, pn_m[0]);
        seen_flush = 1'b0;
        for (int i = 1; i <= int'(DEPTH); i++) begin
            res(TW'(i % int'(DEPTH)), pn_m[i % int'(DEPTH)]);
            seen_flush |= bus.flush;
        end
        for (int i = 0; i < 10; i++) begin
            cyc();
            seen_flush |= bus.flush;
        end
        chk("drain_noflush", 32'(seen_flush), 32'd0);
        chk("drain_cnt", 32'(bus.mispredict_cnt), 32'd0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            chk($sformatf("wrap_tag%0d", i), 32'(bus.pred_tag), 32'((i + 1) % int'(DEPTH)));
            chk($sformatf("wrap_ready%0d", i), 32'(bus.pred_ready), 32'd1);
            enq(32'h6000 + 32'(i), 32'h6004 + 32'(i));
        end
        chk("wrap_full", 32'(bus.pred_ready), 32'd0);

        // Mispredict at head with younger entries; younger result during FLUSH ignored
        do_reset();
        enq(32'h10, 32'h14);
        enq(32'h20, 32'h24);
        enq(32'h30, 32'h34);
        enq(32'h40, 32'h44);
        res(3'd0, 32'h777);
        cyc();
        chk_all("young_flush", 1'b0, 3'd0, 1'b1, 32'h777, 32'h10, 16'd1);
        res(3'd1, 32'h24);
        cyc();
        chk("young_ready", 32'(bus.pred_ready), 32'd1);
        chk("young_tag", 32'(bus.pred_tag), 32'd0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            chk($sformatf("young_empty%0d", i), 32'(bus.pred_ready), 32'd1);
            enq(32'h7000 + 32'(i), 32'h7004 + 32'(i));
        end
        chk("young_full", 32'(bus.pred_ready), 32'd0);
        chk("young_noflush", 32'(bus.flush), 32'd0);

        // Reset pulse in FLUSH
        do_reset();
        enq(32'h50, 32'h54);
        res(3'd0, 32'h99);
        cyc();
        chk("rstflush_pre", 32'(bus.flush), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_all("rstflush", 1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 16'd0);
        cyc();
        cyc();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rstflush_ready", 32'(bus.pred_ready), 32'd1);
        seen_flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            seen_flush |= bus.flush;
        end
        chk("rstflush_nopulse", 32'(seen_flush), 32'd0);
        chk_all("rstflush_end", 1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter: DEPTH, 8, in-flight prediction entries; power of two, 2..64; TW = log2(DEPTH).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low.
REQ-004 pred_valid  in  1  fetch enqueues a predicted control-flow instruction.
REQ-005 pred_pc  in  32  PC of the enqueued instruction.
REQ-006 pred_next  in  32  next PC predicted by fetch (BTB hit target or PC+4).
REQ-007 pred_ready  out  1  an entry can be accepted this cycle.
REQ-008 pred_tag  out  TW  tag given to the entry accepted this cycle (tail index).
REQ-009 res_valid  in  1  branch execution reports an actual outcome.
REQ-010 res_tag  in  TW  tag of the resolved entry.
REQ-011 res_target  in  32  actual next PC of the resolved instruction.
REQ-012 flush  out  1  one-cycle mispredict pulse; also the BTB write enable.
REQ-013 flush_pc  out  32  redirect PC; also the BTB next-PC write data.
REQ-014 flush_src_pc  out  32  PC of the mispredicted instruction; BTB index and tag source.
REQ-015 mispredict_cnt  out  16  saturating count of flushes issued.

Function
REQ-016 Storage: DEPTH entries of {valid, resolved, pc[31:0], pred_next[31:0], actual[31:0]}; head pointer, tail pointer, and count of width TW+1.
REQ-017 Enqueue: on a pred_valid && pred_ready edge, write entry[tail] with valid=1, resolved=0, pc and pred_next; tail increments modulo DEPTH and wraps from DEPTH-1 to 0.
REQ-018 pred_ready = (state==RUN) && (count<DEPTH); pred_tag = tail; pred_valid with pred_ready=0 is dropped with no state change.
REQ-019 Resolve: on a res_valid edge where entry[res_tag].valid=1, set resolved=1 and actual=res_target; a repeat resolve before retire overwrites actual; res_valid on an invalid entry is ignored.
REQ-020 Resolutions may arrive in any order; retirement is strictly in program order from head, at most one entry per cycle.
REQ-021 Retire condition: state==RUN && entry[head].valid && entry[head].resolved, evaluated from registered state.
REQ-022 Correct retire (actual==pred_next, full 32-bit compare): clear entry[head], head+1 mod DEPTH, no flush.
REQ-023 Mispredict retire (actual!=pred_next): register flush=1, flush_pc=actual, flush_src_pc=pc; invalidate all entries; head=tail=count=0; mispredict_cnt+1, saturating at 16'hFFFF; state moves to FLUSH.
REQ-024 Latency: res_valid sampled on the edge ending cycle c for the head entry gives a retire on the edge ending c+1; on a mispredict, flush is high during cycle c+2.
REQ-025 FSM RUN->FLUSH on a mispredict retire; FLUSH->RECOVER unconditionally; RECOVER->RUN unconditionally; flush=1 only in FLUSH.
REQ-026 In FLUSH and RECOVER: pred_ready=0; res_valid is ignored (wrong-path results); no retire.
REQ-027 flush_pc and flush_src_pc hold their last values outside FLUSH.
REQ-028 Enqueue and correct retire in the same cycle: count is unchanged; pointers move independently.
REQ-029 pred_ready is derived from registered count only; a full queue does not accept an entry in the same cycle that frees a slot.
REQ-030 Resolve and enqueue in the same cycle to different tags both take effect; a resolve cannot target the tail slot being written (that slot is invalid).

Reset
REQ-031 When rst is low, asynchronously: all entry valid/resolved bits=0, head=tail=count=0, state=RUN, flush=0, flush_pc=0, flush_src_pc=0, mispredict_cnt=0.
REQ-032 rst asserted mid-operation, including in FLUSH or RECOVER, discards all in-flight entries, and no flush pulse is produced afterwards.
REQ-033 After rst releases, pred_ready=1 on the first cycle.

Verification
REQ-034 Enqueue pc=0x100 pred_next=0x104 (tag 0); resolve tag 0 target=0x104 -> no flush, count returns to 0, mispredict_cnt=0.
REQ-035 Enqueue pc=0x200 pred_next=0x204 (tag 0); resolve target=0x380 in cycle c -> flush=1 in cycle c+2 only, flush_pc=0x380, flush_src_pc=0x200, mispredict_cnt=1, pred_ready=0 in cycles c+2 and c+3, and 1 in c+4.
REQ-036 Enqueue tags 0,1,2; resolve 2 (mispredict), then 1 (correct), then 0 (correct) -> tags 0 and 1 retire in order, then the flush for tag 2 with flush_src_pc equal to tag 2's pc.
REQ-037 Enqueue DEPTH entries -> pred_ready=0, an extra pred_valid is dropped; retire one entry -> pred_ready=1 the next cycle; a further DEPTH enqueues wrap the tag from DEPTH-1 to 0.
REQ-038 Mispredict at head with 3 younger entries, and res_valid for a younger tag during FLUSH -> the younger result is ignored, count=0 after the flush, the next pred_tag is 0.
REQ-039 Pulse rst low during FLUSH -> flush=0 immediately, mispredict_cnt=0, all outputs at reset values, no later flush pulse.
